// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multicycle MIPS datapath.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_control #(
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       halted
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_HALT,
        S_BNEBR
    } state_t;

    state_t state_q, state_d;

    logic pcwrite;
    logic branch;
    logic branch_ne;
    logic memwrite_s;
    logic irwrite_s;
    logic regwrite_s;
    logic done_s;

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return ALU_ADD;
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        iord       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        done_s     = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                alusrcb   = 2'b01;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = S_BNEBR;
`endif
                    default: state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                done_s     = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu(funct);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                done_s     = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MULTICYCLE_BNE_EN
            S_BNEBR: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch_ne  = 1'b1;
                pcsrc      = 2'b01;
                done_s     = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                done_s     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
                done_s  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset gates every write enable so an aborted instruction commits nothing
    assign pcen       = ~reset & (pcwrite | (branch & zero) | (branch_ne & ~zero));
    assign irwrite    = ~reset & irwrite_s;
    assign regwrite   = ~reset & regwrite_s;
    assign memwrite   = ~reset & memwrite_s;
    assign instr_done = ~reset & done_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a
// cycle-count model of each instruction class.
module tb_multicycle_control;

    localparam int IH = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, halted;

    int checks = 0;
    int errors = 0;
    int k = 0;
    bit hm = 1'b0;
    int hc = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_HALT(IH)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .instr_done(instr_done), .halted(halted)
    );

    function automatic int ilen(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
`ifdef MULTICYCLE_BNE_EN
            6'b000101: return 3;
`endif
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs from instruction class and cycle index k (0 = fetch)
    function automatic logic [16:0] expv();
        logic pe, io, mw, iw, rd, mr, rw, sa, dn, hl;
        logic [1:0] sb, ps;
        logic [2:0] al;
        {pe, io, mw, iw, rd, mr, rw, sa, dn, hl} = '0;
        sb = 2'b00; ps = 2'b00; al = 3'b010;
        if (hm) hl = 1'b1;
        else if (k == 0) begin iw = 1'b1; pe = 1'b1; sb = 2'b01; end
        else if (k == 1) sb = 2'b11;
        else begin
            case (op)
                6'b100011: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                           else if (k == 3) io = 1'b1;
                           else begin mr = 1'b1; rw = 1'b1; dn = 1'b1; end
                6'b101011: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                           else begin io = 1'b1; mw = 1'b1; dn = 1'b1; end
                6'b000000: if (k == 2) begin sa = 1'b1; al = alu_of(funct); end
                           else begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
                6'b000100: begin
                    sa = 1'b1; al = 3'b110; ps = 2'b01; pe = zero; dn = 1'b1;
                end
`ifdef MULTICYCLE_BNE_EN
                6'b000101: begin
                    sa = 1'b1; al = 3'b110; ps = 2'b01; pe = ~zero; dn = 1'b1;
                end
`endif
                6'b001000: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                           else begin rw = 1'b1; dn = 1'b1; end
                6'b000010: begin pe = 1'b1; ps = 2'b10; dn = 1'b1; end
                default: ;
            endcase
        end
        if (reset) begin pe = 1'b0; iw = 1'b0; rw = 1'b0; mw = 1'b0; dn = 1'b0; end
        return {pe, io, mw, iw, rd, mr, rw, sa, sb, ps, al, dn, hl};
    endfunction

    task automatic tick();
        logic r;
        @(posedge clk);
        r = reset;
        if (r) begin k = 0; hm = 1'b0; end
        else if (!hm) begin
            k++;
            if (k >= ilen(op)) begin
                k = 0;
                if (ilen(op) == 2 && IH != 0) hm = 1'b1;
            end
        end
        #1;
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (v) begin k = 0; hm = 1'b0; end
    endtask

    task automatic chk();
        logic [16:0] e, g;
        #1;
        e = expv();
        g = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, alucontrol, instr_done, halted};
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL model k=%0d op=%b funct=%b zero=%b rst=%b got=%b exp=%b",
                     k, op, funct, zero, reset, g, e);
        end
    endtask

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic pick();
        case ($urandom_range(0, 8))
            0: op = 6'b100011;
            1: op = 6'b101011;
            2, 3: op = 6'b000000;
            4: op = 6'b000100;
            5: op = 6'b001000;
            6: op = 6'b000010;
            7: op = 6'b000101;
            default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0: funct = 6'b100000;
            1: funct = 6'b100010;
            2: funct = 6'b100100;
            3: funct = 6'b100101;
            4: funct = 6'b101010;
            default: funct = 6'($urandom);
        endcase
    endtask

    initial begin
        reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk();
            lit("rst_srcb", 8'(alusrcb), 8'h01);
            lit("rst_we", 8'({pcen, irwrite, regwrite, memwrite, instr_done}), 8'h00);
            tick();
        end
        set_reset(1'b0);
        chk();
        lit("rel_pcen", 8'(pcen), 8'h01);
        lit("rel_irw", 8'(irwrite), 8'h01);

        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            chk();
            lit("lw_wb", 8'(regwrite & memtoreg), 8'(c == 5));
            lit("lw_done", 8'(instr_done), 8'(c == 5));
        end
        tick();

        op = 6'b000000; funct = 6'b101010;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            chk();
            if (c == 3) lit("slt_alu", 8'(alucontrol), 8'h07);
            if (c == 4) lit("aluwb", 8'({regdst, regwrite}), 8'h03);
            lit("r_done", 8'(instr_done), 8'(c == 4));
        end
        tick();

        for (int t = 1; t >= 0; t--) begin
            op = 6'b000100; zero = 1'(t);
            for (int c = 1; c <= 3; c++) begin
                if (c > 1) tick();
                chk();
            end
            lit("beq_pcen", 8'(pcen), 8'(t));
            lit("beq_pcsrc", 8'(pcsrc), 8'h01);
            tick();
        end

        op = 6'b111111;
        chk();
        tick();
        chk();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk();
            lit("halt", 8'(halted), 8'h01);
            lit("halt_en", 8'({pcen, irwrite, regwrite, memwrite}), 8'h00);
        end
        set_reset(1'b1);
        chk();
        lit("halt_async_rst", 8'(halted), 8'h00);
        tick();
        set_reset(1'b0);
        op = 6'b101011;
        chk();
        lit("halt_refetch", 8'(irwrite), 8'h01);

        for (int c = 2; c <= 4; c++) begin
            tick();
            chk();
        end
        lit("sw_mw", 8'(memwrite), 8'h01);
        set_reset(1'b1);
        chk();
        lit("sw_rst_mw", 8'(memwrite), 8'h00);
        tick();
        set_reset(1'b0);
        chk();
        lit("sw_refetch", 8'(irwrite), 8'h01);

        repeat (4000) begin
            tick();
            if (reset) begin
                if ($urandom_range(0, 2) == 0) set_reset(1'b0);
            end else if (hm) begin
                hc++;
                if (hc >= 3) begin set_reset(1'b1); hc = 0; end
            end else if ($urandom_range(0, 49) == 0) begin
                set_reset(1'b1);
            end
            if (k == 0 && !hm) pick();
            zero = 1'($urandom);
            chk();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
